fadd_issue_arbiter: RTL and testbench
=====================================

// Module: fadd_issue_arbiter
// PURPOSE
//  Shares one fadd_pipeline instance between NUM_REQ requesters.
//  Round-robin arbitration issues at most one add per cycle into the fadd.
//  Tracks in-flight ops in a LATENCY-deep shift register and captures results into a RES_DEPTH FIFO.
//  A credit counter guarantees every issued op has a FIFO slot, so the stall-free fadd never loses a result.
// PARAMETERS
//  NUM_REQ    2  number of requesters (2..8)
//  TAG_W      4  requester-supplied tag width, returned with the result
//  LATENCY    4  cycles from fadd_a/fadd_b driven to fadd_result valid (input reg + 3 stage regs)
//  RES_DEPTH  8  result FIFO entries; also total credit pool (power of 2, >= 2)
// PORTS
//  clk        in   1                  clock
//  rst_n      in   1                  async reset, active low; shared with fadd_pipeline
//  req_valid  in   NUM_REQ            requester i has an operation
//  req_ready  out  NUM_REQ            one-hot grant; handshake when valid&ready
//  req_a      in   NUM_REQ*32         operand A per requester, packed [i*32 +: 32]
//  req_b      in   NUM_REQ*32         operand B per requester
//  req_tag    in   NUM_REQ*TAG_W      tag per requester
//  fadd_a     out  32                 to fadd_pipeline.input_a
//  fadd_b     out  32                 to fadd_pipeline.input_b
//  fadd_result in  32                 from fadd_pipeline.result
//  res_valid  out  1                  FIFO head valid
//  res_ready  in   1                  consumer accepts head
//  res_data   out  32                 sum
//  res_id     out  $clog2(NUM_REQ)    issuing requester index
//  res_tag    out  TAG_W              issuing requester's tag
// BEHAVIOUR
//  - Reset: req_ready=0, res_valid=0, res_data/res_id/res_tag=0, fadd_a/b=0, rr pointer=0, tracker cleared, FIFO empty, credits=RES_DEPTH.
//  - Credits: decrement on issue, increment on FIFO pop; both in the same cycle leave it unchanged. Never exceeds RES_DEPTH and never goes below 0.
//  - Arbitration (combinational): if credits>0, grant the first req_valid at or after rr pointer, modulo NUM_REQ. req_ready=0 for every requester when credits==0 or no request is valid.
//  - req_ready is combinational on req_valid. A requester must not make req_valid depend on req_ready.
//  - On issue, the rr pointer becomes grant+1 mod NUM_REQ. With no issue, the pointer holds.
//  - fadd_a/fadd_b (combinational): granted operands on issue, otherwise 32'h0.
//  - Tracker: trk[0] <= {issue, grant_id, tag}; trk[k] <= trk[k-1]. When trk[LATENCY-1].v is set, fadd_result is valid on that cycle.
//  - Capture: on that same cycle, push {fadd_result, id, tag} into the FIFO. The credit scheme makes push-on-full impossible; an assertion flags it.
//  - FIFO: registered output with no bypass. res_valid rises the cycle after the first push into an empty FIFO.
//  - Issue-to-res_valid latency is LATENCY+1 cycles with an empty FIFO. Results leave in issue order.
//  - Simultaneous push and pop: allowed at any occupancy, including full, and occupancy is unchanged.
//  - res_* hold stable while res_valid && !res_ready.
//  - Reset mid-operation: all in-flight ops and FIFO contents are discarded, with no partial result. fadd_pipeline resets on the same rst_n.
//  - Operand semantics (normals only, no NaN/Inf) are inherited from fadd_pipeline unchanged.
// CONFIGURATION
//  FADD_ARB_PERF_EN defined:
//   - Adds outputs perf_issue_cnt [31:0] (issues) and perf_stall_cnt [31:0] (cycles with any req_valid, credits==0).
//   - Both counters wrap at 2^32 and reset to 0.
//  Undefined: these ports and their counters do not exist; all other behaviour is identical.
// TESTING
//  1. req0 a=32'h3F800000 b=32'h40000000 tag=3, res_ready=1
//     -> res_valid at issue+5 cycles; res_data=32'h40400000, res_id=0, res_tag=3.
//  2. Both requesters valid continuously, res_ready=1
//     -> grants alternate 0,1,0,1; one issue per cycle; no results lost.
//  3. res_ready=0, req0 valid continuously
//     -> exactly 8 issues, then req_ready=0. Set res_ready=1: 8 results drain in issue order, then issuing resumes.
//  4. credits==0, FIFO full, res_ready=1 and a pending request
//     -> pop occurs; issue occurs the next cycle; credits never exceed 8.
//  5. Assert rst_n low with 3 ops in flight and 2 in FIFO
//     -> outputs reset immediately; after release, no stale res_valid; credits=8.
//  6. FADD_ARB_PERF_EN defined, scenario 3
//     -> perf_issue_cnt=8 before release; perf_stall_cnt counts every blocked cycle.

Source files
------------

// File: rtl/fadd_issue_arbiter_if.sv
// fadd_issue_arbiter_if: requester and result handshake bundle for fadd_issue_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface fadd_issue_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*32-1:0]    req_a;
    logic [NUM_REQ*32-1:0]    req_b;
    logic [NUM_REQ*TAG_W-1:0] req_tag;

    logic                     res_valid;
    logic                     res_ready;
    logic [31:0]              res_data;
    logic [ID_W-1:0]          res_id;
    logic [TAG_W-1:0]         res_tag;

    modport master (
        output req_valid, req_a, req_b, req_tag, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, res_ready,
        output req_ready, res_valid, res_data, res_id, res_tag
    );
endinterface

// File: rtl/fadd_issue_arbiter.sv
// fadd_issue_arbiter: round-robin issue of NUM_REQ requesters into one shared,
// stall-free fadd pipeline. In-flight ops are tracked in a LATENCY-deep shift
// register; results land in a RES_DEPTH FIFO whose slots are reserved by a
// credit counter at issue time, so a result can never arrive to a full FIFO.
// Optional feature macro: FADD_ARB_PERF_EN adds perf_issue_cnt / perf_stall_cnt.
module fadd_issue_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int TAG_W     = 4,
    parameter int LATENCY   = 4,
    parameter int RES_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fadd_issue_arbiter_if.slave bus,
    output logic [31:0]         fadd_a,
    output logic [31:0]         fadd_b,
    input  logic [31:0]         fadd_result
`ifdef FADD_ARB_PERF_EN
    ,
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ID_W:0]    NUM_REQ_X = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RES_DEPTH);

    typedef struct packed {
        logic             v;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } trk_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } res_t;

    // Unpacked per-requester views of the packed operand buses
    logic [31:0]      a_arr   [NUM_REQ];
    logic [31:0]      b_arr   [NUM_REQ];
    logic [TAG_W-1:0] tag_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]   = bus.req_a[gi*32 +: 32];
            assign b_arr[gi]   = bus.req_b[gi*32 +: 32];
            assign tag_arr[gi] = bus.req_tag[gi*TAG_W +: TAG_W];
        end
    endgenerate

    // State
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] credits_q, credits_d;
    trk_t             trk_q [LATENCY];
    trk_t             trk_d [LATENCY];

    res_t             mem [RES_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic             head_valid_q, head_valid_d;
    res_t             head_q, head_d;

    logic             issue;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W:0]    cand_x;
    logic [ID_W-1:0]  cand;

    logic             push;
    logic             pop;
    res_t             push_ent;
    logic             load_head;
    logic             mem_push;
    logic             mem_pop;

    // Round-robin search from rr_q; nothing is granted without a free credit or during reset
    always_comb begin
        issue    = 1'b0;
        grant_id = '0;
        cand_x   = '0;
        cand     = '0;
        if (rst_n && credits_q != '0) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                cand_x = {1'b0, rr_q} + (ID_W + 1)'(off);
                if (cand_x >= NUM_REQ_X) begin
                    cand_x = cand_x - NUM_REQ_X;
                end
                cand = cand_x[ID_W-1:0];
                if (!issue && bus.req_valid[cand]) begin
                    issue    = 1'b1;
                    grant_id = cand;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = issue && (grant_id == ID_W'(gi));
        end
    endgenerate

    assign fadd_a = issue ? a_arr[grant_id] : 32'h0;
    assign fadd_b = issue ? b_arr[grant_id] : 32'h0;

    // Pointer advances past the winner only when something issued
    always_comb begin
        rr_d = rr_q;
        if (issue) begin
            rr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
    end

    // Credits: one consumed per issue, one returned per result popped
    always_comb begin
        credits_d = credits_q - {{(CNT_W-1){1'b0}}, issue} + {{(CNT_W-1){1'b0}}, pop};
    end

    // In-flight tracker: slot LATENCY-1 lines up with fadd_result being valid
    always_comb begin
        trk_d[0] = '0;
        if (issue) begin
            trk_d[0].v   = 1'b1;
            trk_d[0].id  = grant_id;
            trk_d[0].tag = tag_arr[grant_id];
        end
        for (int k = 1; k < LATENCY; k++) begin
            trk_d[k] = trk_q[k-1];
        end
    end

    assign push          = trk_q[LATENCY-1].v;
    assign push_ent.data = fadd_result;
    assign push_ent.id   = trk_q[LATENCY-1].id;
    assign push_ent.tag  = trk_q[LATENCY-1].tag;
    assign pop           = head_valid_q && bus.res_ready;

    // FIFO = output head register + backing store; a push into an empty FIFO
    // goes straight to the head register, so res_valid follows one cycle later
    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        load_head    = !head_valid_q || pop;
        mem_pop      = load_head && (mem_cnt_q != '0);
        mem_push     = push && !(load_head && (mem_cnt_q == '0));
        if (load_head) begin
            if (mem_cnt_q != '0) begin
                head_valid_d = 1'b1;
                head_d       = mem[rd_q];
                rd_d         = rd_q + 1'b1;
            end else if (push) begin
                head_valid_d = 1'b1;
                head_d       = push_ent;
            end else begin
                head_valid_d = 1'b0;
            end
        end
        if (mem_push) begin
            wr_d = wr_q + 1'b1;
        end
        mem_cnt_d = mem_cnt_q + {{(CNT_W-1){1'b0}}, mem_push}
                              - {{(CNT_W-1){1'b0}}, mem_pop};
    end

    // Backing store write port; contents need no reset since counts gate every read
    always_ff @(posedge clk) begin
        if (mem_push) begin
            mem[wr_q] <= push_ent;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= '0;
            credits_q    <= FULL_CNT;
            for (int k = 0; k < LATENCY; k++) begin
                trk_q[k] <= '0;
            end
            wr_q         <= '0;
            rd_q         <= '0;
            mem_cnt_q    <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            rr_q         <= rr_d;
            credits_q    <= credits_d;
            for (int k = 0; k < LATENCY; k++) begin
                trk_q[k] <= trk_d[k];
            end
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            mem_cnt_q    <= mem_cnt_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    assign bus.res_valid = head_valid_q;
    assign bus.res_data  = head_q.data;
    assign bus.res_id    = head_q.id;
    assign bus.res_tag   = head_q.tag;

`ifdef FADD_ARB_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Issue count and credit-starved request cycles, both free-running and wrapping
    always_comb begin
        perf_issue_d = perf_issue_q + {31'b0, issue};
        perf_stall_d = perf_stall_q + {31'b0, (|bus.req_valid) && (credits_q == '0)};
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

    // A result arriving with every slot occupied and no pop would be lost
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && ((mem_cnt_q + {{(CNT_W-1){1'b0}}, head_valid_q}) == FULL_CNT)));

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credits_q <= FULL_CNT);

endmodule

// File: tb/tb_fadd_issue_arbiter.sv
// tb_fadd_issue_arbiter: directed + randomized bench for fadd_issue_arbiter with a
// behavioural 4-cycle adder stand-in and a queue-based model of issue order.
module tb_fadd_issue_arbiter;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] fadd_a;
    logic [31:0] fadd_b;
    logic [31:0] fadd_result;
`ifdef FADD_ARB_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fadd_issue_arbiter_if #(.NUM_REQ(2), .TAG_W(4)) bus ();

    fadd_issue_arbiter #(
        .NUM_REQ(2), .TAG_W(4), .LATENCY(4), .RES_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .fadd_a      (fadd_a),
        .fadd_b      (fadd_b),
        .fadd_result (fadd_result)
`ifdef FADD_ARB_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-precision <-> real conversions, valid for zero and normal values
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        int          ex;
        if (f[30:0] == 31'h0) return 0.0;
        ex = int'(f[30:23]) + 896;
        d  = {f[31], ex[10:0], f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          ex;
        if (r == 0.0) return 32'h0;
        d  = $realtobits(r);
        ex = int'(d[62:52]) - 896;
        return {d[63], ex[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] f_of(input int n);
        return r2f(real'(n));
    endfunction

    // Stand-in for fadd_pipeline: input register + 3 stages
    logic [31:0] fp_st [4];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) fp_st[k] <= 32'h0;
        end else begin
            fp_st[0] <= r2f(f2r(fadd_a) + f2r(fadd_b));
            for (int k = 1; k < 4; k++) fp_st[k] <= fp_st[k-1];
        end
    end
    assign fadd_result = fp_st[3];

    typedef struct {
        logic [31:0] data;
        int          id;
        logic [3:0]  tag;
        int          avail;
    } exp_t;

    exp_t       exp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         outstanding = 0;
    int         rr_m = 0;
    int         issue_m = 0;
    int         stall_m = 0;
    int         n_ready_seen = 0;
    int         cur_na [2];
    int         cur_nb [2];
    logic [3:0] cur_tag [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_op(input int i, input int na, input int nb, input logic [3:0] tg);
        cur_na[i]  = na;
        cur_nb[i]  = nb;
        cur_tag[i] = tg;
        bus.req_a[i*32 +: 32]  = f_of(na);
        bus.req_b[i*32 +: 32]  = f_of(nb);
        bus.req_tag[i*4 +: 4]  = tg;
    endtask

    task automatic new_op(input int i);
        set_op(i, int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)), 4'($urandom));
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance it
    task automatic step();
        int         g;
        logic [1:0] er;
        logic       erv;
        exp_t       e;
        g  = -1;
        er = 2'b00;
        @(negedge clk);
        if (bus.req_valid != 2'b00 && outstanding == DEPTH) stall_m++;
        if (outstanding < DEPTH) begin
            for (int off = 0; off < 2; off++) begin
                int idx;
                idx = (rr_m + off) % 2;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        if (g >= 0) begin
            chk("fadd_a", 64'(fadd_a), 64'(f_of(cur_na[g])));
            chk("fadd_b", 64'(fadd_b), 64'(f_of(cur_nb[g])));
        end else begin
            chk("fadd_a_idle", 64'(fadd_a), 64'h0);
            chk("fadd_b_idle", 64'(fadd_b), 64'h0);
        end
        if (bus.req_ready != 2'b00) n_ready_seen++;
        erv = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        chk("res_valid", 64'(bus.res_valid), 64'(erv));
        if (erv) begin
            chk("res_data", 64'(bus.res_data), 64'(exp_q[0].data));
            chk("res_id", 64'(bus.res_id), 64'(exp_q[0].id));
            chk("res_tag", 64'(bus.res_tag), 64'(exp_q[0].tag));
            if (bus.res_ready) begin
                e = exp_q.pop_front();
                outstanding--;
                $display("cycle %0d: result id=%0d tag=%0h data=%h", cyc, e.id, e.tag, e.data);
            end
        end
        if (g >= 0) begin
            e.data  = f_of(cur_na[g] + cur_nb[g]);
            e.id    = g;
            e.tag   = cur_tag[g];
            e.avail = cyc + 5;
            exp_q.push_back(e);
            outstanding++;
            issue_m++;
            rr_m = (g + 1) % 2;
            $display("cycle %0d: issue req=%0d a=%h b=%h tag=%0h", cyc, g,
                     f_of(cur_na[g]), f_of(cur_nb[g]), cur_tag[g]);
        end
        @(posedge clk);
        #1;
        if (g >= 0) new_op(g);
        cyc++;
    endtask

    task automatic drain();
        bus.req_valid = 2'b00;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() > 0 || outstanding > 0); i++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic chk_perf();
`ifdef FADD_ARB_PERF_EN
        chk("perf_issue", 64'(perf_issue_cnt), 64'(issue_m));
        chk("perf_stall", 64'(perf_stall_cnt), 64'(stall_m));
`endif
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.res_ready = 1'b0;
        new_op(0);
        new_op(1);

        // Reset state, with requests present that must not be granted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'h0);
        chk("rst_res_data", 64'(bus.res_data), 64'h0);
        chk("rst_res_id", 64'(bus.res_id), 64'h0);
        chk("rst_res_tag", 64'(bus.res_tag), 64'h0);
        chk("rst_fadd_a", 64'(fadd_a), 64'h0);
        chk("rst_fadd_b", 64'(fadd_b), 64'h0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.0 + 2.0 from requester 0, tag 3: result at issue+5
        set_op(0, 1, 2, 4'd3);
        chk("t1_fadd_a_const", 64'(bus.req_a[31:0]), 64'h3F800000);
        bus.req_valid = 2'b01;
        bus.res_ready = 1'b1;
        step();
        bus.req_valid = 2'b00;
        repeat (4) step();
        #3;
        chk("t1_res_valid", 64'(bus.res_valid), 64'h1);
        chk("t1_res_data", 64'(bus.res_data), 64'h40400000);
        chk("t1_res_id", 64'(bus.res_id), 64'h0);
        chk("t1_res_tag", 64'(bus.res_tag), 64'h3);
        drain();

        // Both requesters continuously valid: alternate grants, one issue per cycle
        bus.req_valid = 2'b11;
        n_ready_seen  = 0;
        repeat (20) step();
        chk("t2_issue_per_cycle", 64'(n_ready_seen), 64'd20);
        drain();

        // Consumer stalled: exactly DEPTH issues, then drain and resume
        bus.res_ready = 1'b0;
        bus.req_valid = 2'b01;
        n_ready_seen  = 0;
        repeat (14) step();
        chk("t3_issue_cnt", 64'(n_ready_seen), 64'd8);
        chk_perf();
        bus.res_ready = 1'b1;
        repeat (14) step();
        drain();
        chk_perf();

        // Randomized traffic with periods of heavy back-pressure
        for (int i = 0; i < 300; i++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            if (((i / 40) % 2) == 1) bus.res_ready = ($urandom_range(0, 9) < 2);
            else                     bus.res_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        drain();
        chk_perf();

        // Reset with ops both in flight and in the FIFO
        bus.res_ready = 1'b0;
        bus.req_valid = 2'b01;
        repeat (5) step();
        bus.req_valid = 2'b00;
        step();
        chk("t5_pre_res_valid", 64'(bus.res_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_res_valid", 64'(bus.res_valid), 64'h0);
        chk("t5_rst_res_data", 64'(bus.res_data), 64'h0);
        chk("t5_rst_req_ready", 64'(bus.req_ready), 64'h0);
        exp_q.delete();
        outstanding = 0;
        rr_m        = 0;
        issue_m     = 0;
        stall_m     = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_perf();
        bus.res_ready = 1'b1;
        repeat (12) step();
        bus.res_ready = 1'b0;
        bus.req_valid = 2'b01;
        n_ready_seen  = 0;
        repeat (12) step();
        chk("t5_full_credits", 64'(n_ready_seen), 64'd8);
        drain();
        chk_perf();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
